// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch constants: memory geometry, instruction width, FSM encoding.
package fetch_ctrl_pkg;

  localparam int IMEM_ADDR_WIDTH = 12;
  localparam int IMEM_DATA_WIDTH = 128;
  localparam int RV32_INST_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // The last word of a line has no partner slot, so only one instruction is taken.
  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return (pc[3:2] == 2'd3) ? pc + 32'd4 : pc + 32'd8;
  endfunction

endpackage

// File: rtl/fetch_ctrl_inst_sel_unit.sv
// Picks the instruction pair starting at the selected word of a 128-bit line.
// Purely combinational; unused slots are forced to zero.
module inst_sel_unit
  import fetch_ctrl_pkg::*;
(
  input  logic [IMEM_DATA_WIDTH-1:0] i_line,
  input  logic [1:0]                 i_sel,
  input  logic                       i_vld,
  output logic                       o_vld_1,
  output logic                       o_vld_2,
  output logic [RV32_INST_WIDTH-1:0] o_inst_1,
  output logic [RV32_INST_WIDTH-1:0] o_inst_2
);

  logic [1:0] w_sel_p1;
  logic       w_vld_2;

  assign w_sel_p1 = i_sel + 2'd1;
  assign w_vld_2  = i_vld && (i_sel != 2'd3);
  assign o_vld_1  = i_vld;
  assign o_vld_2  = w_vld_2;

  always_comb begin
    o_inst_1 = '0;
    o_inst_2 = '0;
    if (i_vld) begin
      o_inst_1 = i_line[int'(i_sel) * RV32_INST_WIDTH +: RV32_INST_WIDTH];
    end
    if (w_vld_2) begin
      o_inst_2 = i_line[int'(w_sel_p1) * RV32_INST_WIDTH +: RV32_INST_WIDTH];
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch: one imem line read per cycle, pair presented 1 cycle later; stall parks it in a hold buffer.
// Optional FETCH_PERF_CNT_EN adds accepted-instruction and stall-cycle counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_stall,
  input  logic                       i_redirect_vld,
  input  logic [31:0]                i_redirect_pc,
  output logic                       o_imem_rd_en,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_rd_addr,
  input  logic [IMEM_DATA_WIDTH-1:0] i_imem_rd_data,
  output logic                       o_inst_vld_1,
  output logic                       o_inst_vld_2,
  output logic [RV32_INST_WIDTH-1:0] o_inst_1,
  output logic [RV32_INST_WIDTH-1:0] o_inst_2,
  output logic [31:0]                o_inst_pc_1
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                o_perf_inst_cnt,
  output logic [31:0]                o_perf_stall_cnt
`endif
);

  fetch_state_e               r_state, w_state_nxt;
  logic [31:0]                r_pc, w_pc_nxt;
  logic                       r_resp_vld, w_resp_vld_nxt;
  logic [31:0]                r_resp_pc, w_resp_pc_nxt;
  logic [IMEM_DATA_WIDTH-1:0] r_hold_line, w_hold_nxt;
  logic                       w_rd_en;
  logic                       w_out_vld;
  logic [31:0]                w_redir_pc;
  logic [IMEM_DATA_WIDTH-1:0] w_line;

  assign w_redir_pc = i_redirect_pc & ~32'h3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_resp_vld  <= 1'b0;
      r_resp_pc   <= '0;
      r_hold_line <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_resp_vld  <= w_resp_vld_nxt;
      r_resp_pc   <= w_resp_pc_nxt;
      r_hold_line <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_resp_vld_nxt = r_resp_vld;
    w_resp_pc_nxt  = r_resp_pc;
    w_hold_nxt     = r_hold_line;
    w_rd_en        = 1'b0;
    w_out_vld      = 1'b0;
    if (i_redirect_vld) begin
      w_pc_nxt       = w_redir_pc;
      w_resp_vld_nxt = 1'b0;
      w_hold_nxt     = '0;
      w_state_nxt    = ST_RUN;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_nxt = ST_RUN;
        ST_RUN: begin
          w_out_vld = r_resp_vld;
          if (!i_stall) begin
            w_rd_en        = 1'b1;
            w_pc_nxt       = next_fetch_pc(r_pc);
            w_resp_vld_nxt = 1'b1;
            w_resp_pc_nxt  = r_pc;
          end else if (r_resp_vld) begin
            // Live line is only on the bus this cycle; park it for the stall.
            w_hold_nxt  = i_imem_rd_data;
            w_state_nxt = ST_HOLD;
          end
        end
        ST_HOLD: begin
          w_out_vld = r_resp_vld;
          if (!i_stall) begin
            w_rd_en        = 1'b1;
            w_pc_nxt       = next_fetch_pc(r_pc);
            w_resp_vld_nxt = 1'b1;
            w_resp_pc_nxt  = r_pc;
            w_state_nxt    = ST_RUN;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_line         = (r_state == ST_HOLD) ? r_hold_line : i_imem_rd_data;
  assign o_imem_rd_en   = w_rd_en;
  assign o_imem_rd_addr = r_pc[IMEM_ADDR_WIDTH+3:4];
  assign o_inst_pc_1    = w_out_vld ? r_resp_pc : 32'h0;

  inst_sel_unit u_inst_sel (
    .i_line   (w_line),
    .i_sel    (r_resp_pc[3:2]),
    .i_vld    (w_out_vld),
    .o_vld_1  (o_inst_vld_1),
    .o_vld_2  (o_inst_vld_2),
    .o_inst_1 (o_inst_1),
    .o_inst_2 (o_inst_2)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [1:0] w_acc_cnt;

  assign w_acc_cnt = {1'b0, o_inst_vld_1} + {1'b0, o_inst_vld_2};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_inst_cnt  <= '0;
      o_perf_stall_cnt <= '0;
    end else if (!i_stall) begin
      o_perf_inst_cnt  <= o_perf_inst_cnt + {30'b0, w_acc_cnt};
    end else if (o_inst_vld_1) begin
      o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch PC loaded on reset.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_stall  input  1  decode not ready; output pair not consumed this cycle.
REQ-005 i_redirect_vld  input  1  branch/flush redirect request.
REQ-006 i_redirect_pc  input  32  redirect target; bits [1:0] ignored.
REQ-007 o_imem_rd_en  output  1  imem read strobe.
REQ-008 o_imem_rd_addr  output  IMEM_ADDR_WIDTH  16-byte line address, equal to pc[IMEM_ADDR_WIDTH+3:4].
REQ-009 i_imem_rd_data  input  IMEM_DATA_WIDTH (128)  line returned exactly one cycle after rd_en.
REQ-010 o_inst_vld_1, o_inst_vld_2  output  1 each  slot valids.
REQ-011 o_inst_1, o_inst_2  output  RV32_INST_WIDTH each  instruction slots.
REQ-012 o_inst_pc_1  output  32  PC of slot 1; slot 2 PC is o_inst_pc_1+4.

Function
REQ-013 States SHALL be IDLE, RUN, HOLD; reset enters IDLE; IDLE->RUN after one cycle with no read issued.
REQ-014 In RUN with !i_stall and !i_redirect_vld, rd_en=1 for pc_q; pc_q advances by 4 when pc_q[3:2]==3, else by 8.
REQ-015 A response flag resp_vld_q and resp_pc_q SHALL be set the cycle after each read; slot select = resp_pc_q[3:2].
REQ-016 Slot mapping per select: 0->(w0,w1), 1->(w1,w2), 2->(w2,w3), 3->(w3, invalid); o_inst_vld_1=resp valid, o_inst_vld_2=resp valid & select!=3.
REQ-017 Fetch-to-output latency SHALL be 1 cycle after rd_en; sustained throughput 2 instructions/cycle for aligned-pair streams.
REQ-018 i_stall with valid response: line captured into hold buffer, RUN->HOLD, no read issued, outputs driven from hold buffer and stable.
REQ-019 HOLD->RUN when i_stall=0; held pair counts consumed that cycle and a read for pc_q issues in that same cycle.
REQ-020 i_stall with no valid response: no read, pc_q unchanged, no state change.
REQ-021 i_redirect_vld has priority over all events: pc_q<=i_redirect_pc with bits[1:0] forced 0, resp_vld_q and hold buffer cleared, both valids 0 that cycle, next state RUN, no read that cycle.
REQ-022 Redirect simultaneous with i_stall or during HOLD SHALL behave identically to REQ-021.
REQ-023 pc_q SHALL wrap modulo 2^32 without error.
REQ-024 Invalid slots SHALL drive 0 on o_inst_*.

Reset
REQ-025 On i_rst_n=0: pc_q=RESET_PC, state IDLE, resp_vld_q=0, hold buffer 0, o_imem_rd_en=0, all o_inst_vld_*=0, o_inst_*=0, o_inst_pc_1=0.
REQ-026 Reset asserted mid-HOLD or with a read in flight SHALL discard the in-flight response.

Configuration
REQ-027 Macro FETCH_PERF_CNT_EN defined: add outputs o_perf_inst_cnt[31:0] (+number of valid slots accepted, i.e. valid and !i_stall) and o_perf_stall_cnt[31:0] (+1 per cycle with valid output and i_stall); both reset to 0, wrap at 2^32.
REQ-028 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-029 IMEM_ADDR_WIDTH, IMEM_DATA_WIDTH, RV32_INST_WIDTH and state encodings SHALL come from the shared constants header.
REQ-030 Slot selection SHALL reuse the existing inst_sel_unit as the single sub-module, fed by the muxed live/held line and select.

Verification
REQ-031 RESET_PC=0, no stall: rd_addr 0,0,1,... ; outputs pc 0x0,0x8,0x10 each with both valids 1.
REQ-032 Redirect to 0x10C: next output pc 0x10C, vld_2=0; following pc 0x110 with both valids 1.
REQ-033 Stall 3 cycles while pc 0x8 pair valid: outputs and o_inst_pc_1 stable, rd_en=0; release -> pc 0x10 next cycle.
REQ-034 Redirect to 0x200 during HOLD: valids 0 that cycle, held data discarded, next output pc 0x200.
REQ-035 pc 0xFFFF_FFF8: next pc 0x0 after wrap, no X on outputs.
REQ-036 With FETCH_PERF_CNT_EN, 10 aligned pairs plus 2 stall cycles: o_perf_inst_cnt=20, o_perf_stall_cnt=2.
